bram_stream_reader: RTL and testbench
=====================================

# bram_stream_reader

Read-side sequencer for the 256×16 single-cycle block RAM: on a start command it walks a contiguous (wrapping) address range, drives the RAM's read-enable/read-address port, captures the returned words and presents them as a valid/ready stream with a last marker. It sits between the block RAM and any downstream consumer (UART transmitter, LED driver, DSP stage) that needs the stored table streamed out with backpressure.

## Interface
- ADDR_W, 8: RAM address width; RAM depth is 2^ADDR_W.
- DATA_W, 16: RAM word width.
- FIFO_DEPTH, 4: output buffer entries; power of two, minimum 2.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only when busy=0.
- base_addr  in  ADDR_W  first address; sampled with start.
- len  in  ADDR_W+1  word count, 0..2^ADDR_W; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the final word has been accepted.
- mem_r_en  out  1  RAM read enable.
- mem_r_addr  out  ADDR_W  RAM read address.
- mem_data  in  DATA_W  RAM read data.
- mem_valid  in  1  RAM read-data valid, one cycle after mem_r_en.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from consumer.
- m_last  out  1  high with the final word of the transfer.
- checksum  out  DATA_W  present only with BRAM_STREAM_READER_CHECKSUM_EN.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: start=1 with len≥1 → latch base_addr/len, busy=1, go ISSUE. start=1 with len=0 → done pulses next cycle, busy stays 0, no reads. start while busy ignored.
- ISSUE: issue one read per cycle while occupancy+outstanding < FIFO_DEPTH; address increments mod 2^ADDR_W (base 250, len 10 reads 250..255, 0..3). After the len-th read → DRAIN.
- DRAIN: wait until all outstanding reads are buffered and the FIFO is empty → done=1 for one cycle, busy=0, IDLE.
- mem_valid with outstanding=0 is discarded (stale read across reset).
- Beat transfers when m_valid && m_ready; m_data/m_last held stable while m_valid && !m_ready.
- m_last asserted on exactly the len-th word; never on others.
- Occupancy counter saturates at FIFO_DEPTH by construction (credit rule); simultaneous push and pop leaves occupancy unchanged.

## Timing
- Reset values: busy=0, done=0, mem_r_en=0, mem_r_addr=0, m_valid=0, m_last=0, m_data=0, checksum=0; FIFO, counters, outstanding cleared.
- start in cycle T → mem_r_en=1, mem_r_addr=base_addr in T+1; mem_valid in T+2; m_valid in T+3.
- With m_ready held high: one word per cycle sustained, len words in cycles T+3..T+2+len, done in T+3+len.
- m_ready low: reads stop once FIFO_DEPTH words are buffered or in flight; resume the cycle after a pop frees a slot.
- rst mid-transfer: all outputs to reset values next cycle; in-flight and buffered words dropped; no done pulse.
- start in the same cycle as done: ignored (busy-derived); accepted from the following cycle.

## Configuration
- BRAM_STREAM_READER_CHECKSUM_EN defined: checksum port exists; cleared on accepted start; adds each transferred word mod 2^DATA_W; final value valid in the done cycle and held until the next start or rst.
- Undefined: no checksum port, no adder logic.

## Structure
- Package bram_stream_reader_pkg: ADDR_W/DATA_W defaults, state enum (IDLE, ISSUE, DRAIN).
- Sub-module bram_stream_reader_fifo: FIFO_DEPTH-entry synchronous FIFO carrying {last, data}, with occupancy output; top holds FSM, address/count/outstanding counters, checksum.

## Test plan
- RAM preloaded 1,2,3,1,2,3,... ; start base=0 len=11, m_ready=1 → words 1,2,3,1,2,3,1,2,3,1,2; m_last on 11th; done at T+14.
- base=250 len=10 → mem_r_addr 250..255,0..3; 10 words in order; m_last on 10th.
- len=0 → no mem_r_en, no m_valid, done one cycle after start.
- m_ready toggled 1/0 randomly, len=32 → no word lost or duplicated; mem outstanding+occupancy never exceeds 4; data stable while stalled.
- rst asserted two cycles after first m_valid, then new start base=5 len=3 → no done from aborted run, stale mem_valid ignored, words mem[5..7] only.
- Checksum build: words 0xFFFF,0x0002 → checksum 0x0001 in done cycle.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg
// Shared defaults and the sequencer state encoding for bram_stream_reader.
//   DEF_ADDR_W     : default RAM address width (depth = 2**DEF_ADDR_W)
//   DEF_DATA_W     : default RAM word width
//   DEF_FIFO_DEPTH : default output buffer depth (power of two, >= 2)
//   state_t        : IDLE / ISSUE / DRAIN
package bram_stream_reader_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// bram_stream_reader_fifo
// Synchronous FIFO holding {last, data} words returned by the RAM.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears storage)
//   push, push_data : write one entry (caller guarantees free space)
//   pop             : remove head entry (ignored when empty)
//   head_data       : current head entry
//   head_valid      : FIFO non-empty
//   occupancy       : number of stored entries, 0..DEPTH
module bram_stream_reader_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop     = pop && (occupancy != '0);
  assign head_data  = store[rd_ptr];
  assign head_valid = (occupancy != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      occupancy <= occupancy + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Streams a contiguous, wrapping range of a single-cycle block RAM out as a
// valid/ready stream with a last marker.
// Optional feature: define BRAM_STREAM_READER_CHECKSUM_EN to add the
// checksum port (running sum mod 2**DATA_W of transferred words).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, base_addr, len : command (sampled only when idle and not in done cycle)
//   busy, done          : transfer in progress / one-cycle completion pulse
//   mem_r_en, mem_r_addr, mem_data, mem_valid : RAM read port
//   m_data, m_valid, m_ready, m_last : output stream
//   fsm_state           : current sequencer state (observation)
//   checksum            : only with BRAM_STREAM_READER_CHECKSUM_EN
// Handshake: a beat transfers in any cycle where m_valid && m_ready; while
// m_valid && !m_ready, m_data and m_last are held stable.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output state_t            fsm_state
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
  ,output logic [DATA_W-1:0] checksum
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W:0]   issue_rem;   // reads still to be issued
  logic [ADDR_W:0]   ret_rem;     // words still to come back from the RAM
  logic [CW-1:0]     outstanding; // reads issued but not yet buffered
  logic [CW-1:0]     occupancy;

  logic accept;
  logic can_issue;
  logic issue;
  logic push;
  logic push_last;
  logic pop;
  logic final_beat;

  assign fsm_state = state;

  // Start is ignored in the done cycle so a back-to-back command cannot
  // overlap the completing transfer.
  assign accept    = start && (state == IDLE) && !done;
  // Credit rule: buffered + in-flight never exceeds the FIFO size, so the
  // FIFO can never overflow.
  assign can_issue = ({1'b0, occupancy} + {1'b0, outstanding}) < (CW + 1)'(FIFO_DEPTH);
  assign issue     = (accept && (len != '0)) ||
                     ((state == ISSUE) && (issue_rem != '0) && can_issue);
  // Returns with nothing outstanding are leftovers from before a reset.
  assign push       = mem_valid && (outstanding != '0);
  assign push_last  = (ret_rem == (ADDR_W + 1)'(1));
  assign pop        = m_valid && m_ready;
  assign final_beat = pop && m_last;

  bram_stream_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W + 1)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  ({push_last, mem_data}),
    .pop        (pop),
    .head_data  ({m_last, m_data}),
    .head_valid (m_valid),
    .occupancy  (occupancy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_r_en    <= 1'b0;
      mem_r_addr  <= '0;
      next_addr   <= '0;
      issue_rem   <= '0;
      ret_rem     <= '0;
      outstanding <= '0;
    end else begin
      done        <= 1'b0;
      mem_r_en    <= issue;
      outstanding <= outstanding + CW'(issue) - CW'(push);
      if (push) ret_rem <= ret_rem - (ADDR_W + 1)'(1);

      case (state)
        IDLE: begin
          if (accept) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              busy       <= 1'b1;
              state      <= ISSUE;
              mem_r_addr <= base_addr;
              next_addr  <= base_addr + ADDR_W'(1);
              issue_rem  <= len - (ADDR_W + 1)'(1);
              ret_rem    <= len;
            end
          end
        end
        ISSUE: begin
          if (issue_rem == '0) begin
            state <= DRAIN;
          end else if (can_issue) begin
            mem_r_addr <= next_addr;
            next_addr  <= next_addr + ADDR_W'(1);
            issue_rem  <= issue_rem - (ADDR_W + 1)'(1);
          end
        end
        DRAIN: begin
          // Completion is taken from the final beat below.
        end
        default: state <= IDLE;
      endcase

      // The word tagged last leaves only after every read has returned, so
      // its transfer is the completion point.
      if (busy && final_beat) begin
        done  <= 1'b1;
        busy  <= 1'b0;
        state <= IDLE;
      end
    end
  end

`ifdef BRAM_STREAM_READER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + m_data;
    end
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;
  import bram_stream_reader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int EW     = DATA_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   len = '0;
  logic              busy, done, mem_r_en, m_valid, m_last;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [DATA_W-1:0] mem_data = '0;
  logic              mem_valid = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_ready = 1'b1;
  state_t            fsm_state;
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  bram_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr),
    .mem_data(mem_data), .mem_valid(mem_valid), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .fsm_state(fsm_state)
`ifdef BRAM_STREAM_READER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // ---------------- RAM model (one-cycle read) ----------------
  logic [DATA_W-1:0] ram [256];
  always @(posedge clk) begin
    mem_valid <= mem_r_en;
    if (mem_r_en) mem_data <= ram[mem_r_addr];
  end

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0]     exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  bit   chk_addr  = 1'b0;
  bit   rand_rdy  = 1'b0;
  int   done_cnt  = 0;
  int   done_cyc  = -1;
  int   rd_cnt    = 0;
  int   beat_cnt  = 0;
  int   credit    = 0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_addr_q.delete();
      credit     = 0;
      prev_stall = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_r_en) begin
        rd_cnt++;
        credit++;
        if (chk_addr) begin
          if (exp_addr_q.size() == 0) check("unexpected_read", 32'(mem_r_addr), 32'hFFFF_FFFF);
          else check("read_addr", 32'(mem_r_addr), 32'(exp_addr_q.pop_front()));
        end
      end
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'({m_last, m_data}), 32'({prev_last, prev_data}));
      end
      if (m_valid && m_ready) begin
        beat_cnt++;
        credit--;
        if (exp_q.size() == 0) check("unexpected_beat", 32'({m_last, m_data}), 32'hFFFF_FFFF);
        else check("beat", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
      end
      if (credit > DEPTH) check("credit_limit", 32'(credit), 32'(DEPTH));
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // Consumer ready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l, output int t);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int c0 = done_cnt;
    int k  = 0;
    while (done_cnt == c0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == c0) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int t;
    int dc0;
    int rd0;
    int bt0;
    int k;
    logic [DATA_W-1:0] v1 [11] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2};
    logic [DATA_W-1:0] v2 [10] = '{2, 3, 1, 2, 3, 1, 1, 2, 3, 1};
    logic [ADDR_W-1:0] a2 [10] = '{250, 251, 252, 253, 254, 255, 0, 1, 2, 3};
    logic [DATA_W-1:0] v5 [3]  = '{3, 1, 2};

    for (int i = 0; i < 256; i++) ram[i] = DATA_W'((i % 3) + 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_r_en", 32'(mem_r_en), 32'd0);
    check("rst_mem_r_addr", 32'(mem_r_addr), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));

    // Test 1: base 0, len 11, full-rate consumer
    for (int i = 0; i < 11; i++) push_exp(v1[i], i == 10);
    issue_start(8'd0, 9'd11, t);
    @(negedge clk);
    check("t1_first_r_en", 32'(mem_r_en), 32'd1);
    check("t1_first_addr", 32'(mem_r_addr), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(100, "t1_done");
    check("t1_done_cycle", 32'(done_cyc), 32'(t + 14));
    check("t1_all_words", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Test 2: wrap-around range 250..255, 0..3
    for (int i = 0; i < 10; i++) begin
      push_exp(v2[i], i == 9);
      exp_addr_q.push_back(a2[i]);
    end
    chk_addr = 1'b1;
    issue_start(8'd250, 9'd10, t);
    wait_done(100, "t2_done");
    check("t2_done_cycle", 32'(done_cyc), 32'(t + 13));
    check("t2_all_words", 32'(exp_q.size()), 32'd0);
    check("t2_all_addrs", 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk);
    chk_addr = 1'b0;

    // Test 3: len 0, plus a start in the done cycle that must be ignored
    rd0 = rd_cnt;
    bt0 = beat_cnt;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'd0; len = 9'd0;
    t = cyc;
    @(posedge clk); #1;
    len = 9'd2;                       // still asserted during the done cycle
    @(negedge clk);
    check("t3_done_pulse", 32'(done), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t3_done_single", 32'(done), 32'd0);
    check("t3_start_in_done_ignored", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t3_no_reads", 32'(rd_cnt - rd0), 32'd0);
    check("t3_no_beats", 32'(beat_cnt - bt0), 32'd0);

    // Test 4: random backpressure, base 100, len 32
    for (int i = 0; i < 32; i++) push_exp(ram[100 + i], i == 31);
    rand_rdy = 1'b1;
    issue_start(8'd100, 9'd32, t);
    wait_done(600, "t4_done");
    rand_rdy = 1'b0;
    check("t4_all_words", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);

    // Test 5: reset mid-transfer, then a fresh short transfer
    for (int i = 0; i < 10; i++) push_exp(ram[20 + i], i == 9);
    issue_start(8'd20, 9'd10, t);
    k = 0;
    while (!m_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t5_first_valid_seen", 32'(m_valid), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    dc0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) push_exp(v5[i], i == 2);
    start = 1'b1; base_addr = 8'd5; len = 9'd3;
    t = cyc;
    @(negedge clk);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_m_valid", 32'(m_valid), 32'd0);
    check("t5_rst_mem_r_en", 32'(mem_r_en), 32'd0);
    check("t5_rst_m_data", 32'(m_data), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, "t5_done");
    check("t5_done_cycle", 32'(done_cyc), 32'(t + 6));
    check("t5_one_done", 32'(done_cnt - dc0), 32'd1);
    check("t5_all_words", 32'(exp_q.size()), 32'd0);

`ifdef BRAM_STREAM_READER_CHECKSUM_EN
    // Test 6: checksum wraps mod 2**DATA_W
    ram[10] = 16'hFFFF;
    ram[11] = 16'h0002;
    push_exp(16'hFFFF, 1'b0);
    push_exp(16'h0002, 1'b1);
    issue_start(8'd10, 9'd2, t);
    wait_done(100, "t6_done");
    @(negedge clk);
    check("t6_checksum_held", 32'(checksum), 32'h0001);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, required end before limit", cyc);
    $fatal(1, "timeout");
  end

endmodule
